// File: rtl/rca_pkg.sv
// Shared constants for the byte-serial adder sequencer: adder slice width and FSM encodings.
package rca_pkg;
  localparam int ADD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// 8-bit ripple-carry adder: a chain of full adders, carry propagating from bit 0 upward.
module ripple_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end
endmodule

// File: rtl/rca_seq_ctrl.sv
// Byte-serial add/subtract of WORDS*8-bit operands through a single 8-bit ripple adder,
// LSB byte first, with the carry registered between bytes and valid/ready on both sides.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*ADD_W-1:0] op_a,
  input  logic [WORDS*ADD_W-1:0] op_b,
  input  logic                   op_sub,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*ADD_W-1:0] sum,
  output logic                   cout,
  output logic                   busy
);
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t                       state;
  logic [KW-1:0]                k;
  logic                         carry_q;
  logic [WORDS-1:0][ADD_W-1:0]  a_q;
  logic [WORDS-1:0][ADD_W-1:0]  bx_q;
  logic [WORDS-1:0][ADD_W-1:0]  sum_q;

  logic [ADD_W-1:0] add_sum;
  logic             add_cout;

  ripple_carry_adder u_adder (
    .a    (a_q[k]),
    .b    (bx_q[k]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Subtraction is folded in at accept time: B is inverted and the borrow-in becomes ~cin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      sum_q   <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            bx_q    <= op_sub ? ~op_b : op_b;
            carry_q <= cin ^ op_sub;
            k       <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          sum_q[k] <= add_sum;
          carry_q  <= add_cout;
          if (k == K_LAST) begin
            cout  <= add_cout;
            k     <= '0;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum       = sum_q;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign in_ready  = (state == IDLE) && !rst;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl (WORDS=4): directed vector table, random vectors against an
// arithmetic reference model, backpressure hold and mid-operation reset sequences.
module tb_rca_seq_ctrl;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int passed = 0;
  int total  = 0;

  rca_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         c;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic, no byte slicing.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic c, output logic [W-1:0] s, output logic co);
    logic [W:0] r;
    if (!sub) begin
      r  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      s  = r[W-1:0];
      co = r[W];
    end else begin
      s  = a - b - {{(W-1){1'b0}}, c};
      co = ({1'b0, a} >= ({1'b0, b} + {{W{1'b0}}, c}));
    end
  endtask

  // Issue one request, wait for the result, check it and its latency; leaves DUT in DONE.
  task automatic issue_and_wait(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic c,
                                input logic [W-1:0] es, input logic ec);
    int lat;
    @(negedge clk);
    chk({nm, ".in_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; op_a = a; op_b = b; op_sub = sub; cin = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom); cin = 1'($urandom);
    chk({nm, ".busy"}, 64'(busy), 64'(1));
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".latency"}, 64'(lat), 64'(WORDS));
    chk({nm, ".sum"}, 64'(sum), 64'(es));
    chk({nm, ".cout"}, 64'(cout), 64'(ec));
  endtask

  task automatic handshake(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, ".out_valid_drop"}, 64'(out_valid), 64'(0));
    chk({nm, ".in_ready_after"}, 64'(in_ready), 64'(1));
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] es, hs;
    logic         ec, hc;
    logic [W-1:0] ra, rb;
    logic         rs, rc;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 32'h00000000, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1};
    vecs[5] = '{32'h00000007, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0; cin = 1'b0;
    #3;
    chk("reset.in_ready", 64'(in_ready), 64'(0));
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.sum", 64'(sum), 64'(0));
    chk("reset.cout", 64'(cout), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 6; i++) begin
      issue_and_wait($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].c,
                     vecs[i].exp_sum, vecs[i].exp_cout);
      handshake($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      if (i % 7 == 0) ra = '1;
      if (i % 5 == 0) rb = ra;
      model(ra, rb, rs, rc, es, ec);
      issue_and_wait($sformatf("rnd%0d", i), ra, rb, rs, rc, es, ec);
      handshake($sformatf("rnd%0d", i));
    end

    // Backpressure: result held for 10 clocks while extra requests are offered.
    model(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, hs, hc);
    issue_and_wait("hold", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, hs, hc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      chk("hold.sum", 64'(sum), 64'(hs));
      chk("hold.cout", 64'(cout), 64'(hc));
      chk("hold.in_ready", 64'(in_ready), 64'(0));
      chk("hold.out_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    handshake("hold");
    model(32'h80000000, 32'h00000001, 1'b1, 1'b0, es, ec);
    issue_and_wait("after_hold", 32'h80000000, 32'h00000001, 1'b1, 1'b0, es, ec);
    handshake("after_hold");

    // Reset while byte index is 2.
    @(negedge clk);
    in_valid = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222; op_sub = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'(0));
    chk("midrst.sum", 64'(sum), 64'(0));
    chk("midrst.cout", 64'(cout), 64'(0));
    chk("midrst.busy", 64'(busy), 64'(0));
    chk("midrst.in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.in_ready_rel", 64'(in_ready), 64'(1));
    issue_and_wait("post_rst", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
    handshake("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
